sprite_scan_ctrl: RTL and testbench
===================================

# sprite_scan_ctrl

Raster scan controller and sprite compositor for the 640x480 VGA output path. It generates the pixel/line counters and sync signals that every `draw_sprite` instance consumes, and issues each sprite's one-cycle `start` pulse so the drawer is armed before its first line. It also collects the drawers' `spr_draw` outputs back into a priority-resolved, registered RGB pixel stream aligned with delayed sync. It is the initiator and consumer end of the drawer interface; `clk` is the pixel clock.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch/sync widths (H_TOTAL = 800)
- V_VISIBLE, 480, visible lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch/sync widths (V_TOTAL = 525)
- NUM_SPRITES, 4, number of attached drawers
- COLOR_W, 8, RGB width (3-3-2)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- spr_en  in  NUM_SPRITES  per-sprite enable
- spr_y  in  10*NUM_SPRITES  top line of sprite i at bits [10i+9:10i]
- spr_color  in  COLOR_W*NUM_SPRITES  colour of sprite i
- bg_color  in  COLOR_W  background colour
- spr_draw  in  NUM_SPRITES  drawer outputs
- pixel_x  out  10  horizontal counter (0..H_TOTAL-1)
- pixel_y  out  10  vertical counter (0..V_TOTAL-1)
- spr_start  out  NUM_SPRITES  one-cycle start pulse per drawer
- frame_start  out  1  one-cycle pulse on entry to vertical blank
- hsync, vsync  out  1  active-low syncs, pipeline-aligned with rgb
- video_on  out  1  visible-region flag, aligned with rgb
- rgb  out  COLOR_W  registered pixel colour

## Operation
- Counters: pixel_x increments every clk and wraps from H_TOTAL-1 to 0. On that wrap, pixel_y increments and wraps from V_TOTAL-1 to 0.
- Raw sync: hsync_raw is low for H_VISIBLE+H_FRONT ≤ pixel_x < H_VISIBLE+H_FRONT+H_SYNC. vsync_raw is defined the same way on pixel_y. vis_raw = (pixel_x < H_VISIBLE) && (pixel_y < V_VISIBLE).
- frame_start is high for exactly the cycle where pixel_x==0 and pixel_y==V_VISIBLE.
- Shadow registers: spr_y and spr_en are copied into internal shadow registers in the frame_start cycle. All start decisions use the shadow copies only, so mid-frame input changes have no effect until the next frame.
- Start scheduling: for each i with shadow_en[i]=1 and shadow_y[i] < V_VISIBLE, spr_start[i] pulses for one cycle at pixel_x==H_VISIBLE on line L = shadow_y[i]-1.
  - If shadow_y[i]==0, L = V_TOTAL-1.
  - This arms the drawer during horizontal blank, so spr_x=0 is still caught on line spr_y.
  - Each enabled sprite gets exactly one pulse per frame.
- Sprites with shadow_y ≥ V_VISIBLE are never started.
- Compositor: the drawer asserts spr_draw one cycle after pixel_x matches, so spr_draw arrives at t+1 for counter value t.
  - At t+1, select spr_color of the lowest index i with spr_draw[i]=1; otherwise select bg_color.
  - If the 1-cycle-delayed vis_raw is 0, select 0.
  - The selection is registered into rgb, which is valid at t+2.
- hsync_raw, vsync_raw and vis_raw pass through a 2-stage pipeline. The outputs hsync, vsync and video_on therefore align with rgb.
- The shadow registers and start logic form a small per-sprite FSM.
  - States: IDLE, ARMED (shadow loaded, waiting for line L) and FIRED.
  - IDLE→ARMED on frame_start if the sprite is enabled.
  - ARMED→FIRED on the pulse cycle.
  - FIRED→ARMED or IDLE on the next frame_start.
  - spr_y=0 fires after frame_start within the same frame period, since line 524 follows the latch at line 480.

## Timing
- Reset values: pixel_x=0, pixel_y=0, spr_start=0, frame_start=0, hsync=1, vsync=1, video_on=0, rgb=0, shadows=0, all sprite FSMs IDLE.
- After rst release, counters start at 0,0 on the first clk edge.
- Until the first frame_start, no spr_start is issued, because the shadows are 0 and disabled.
- Pixel latency: counter value t to rgb/hsync/vsync/video_on is 2 cycles.
- rst asserted mid-frame returns all outputs to their reset values immediately. No start pulse is issued until a new frame_start.
- If multiple sprites share the same line, their spr_start pulses fire in the same cycle.
- If multiple spr_draw bits are simultaneously high, the lowest index wins.
- spr_draw is ignored outside the delayed visible region, where rgb=0.

## Test plan
- Reset release, 1 full frame (420000 cycles) -> pixel_x wraps at 799, pixel_y at 524. hsync low for exactly 96 cycles per line at raw x 656..751 (outputs 2 cycles later). vsync low on lines 490..491. frame_start is high exactly once, at (0,480).
- spr_en=0001, spr_y[0]=100, set before frame_start -> spr_start[0] one pulse at pixel_x=640, pixel_y=99. No pulses on other bits.
- spr_y[1]=0, spr_en[1]=1 -> spr_start[1] pulse at (640,524). spr_y[2]=480 -> no pulse.
- Change spr_y[0] from 100 to 200 at line 150 (mid-frame) -> the current frame is unaffected. The next frame pulses at line 199.
- spr_draw=0110 forced when the counter is at (10,10), with colors 0x11/0x22/0x33/0x44 and bg=0x55 -> rgb=0x22 two cycles after counter (10,10). With spr_draw=0 -> 0x55. During hblank -> 0x00 with video_on=0.
- rst pulsed at (300,200) -> all outputs at reset values within the same cycle. Counters restart at 0,0. No spr_start before the next frame_start.

Source files
------------

// File: rtl/sprite_scan_if.sv
// Bundle between the scan controller and the sprite drawers/environment.
// The master side (scan controller) drives the raster, sync, start and pixel outputs.
interface sprite_scan_if #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned COLOR_W     = 8
);
    localparam int unsigned CNT_W = 10;

    logic [NUM_SPRITES-1:0]         spr_en;
    logic [CNT_W*NUM_SPRITES-1:0]   spr_y;
    logic [COLOR_W*NUM_SPRITES-1:0] spr_color;
    logic [COLOR_W-1:0]             bg_color;
    logic [NUM_SPRITES-1:0]         spr_draw;

    logic [CNT_W-1:0]               pixel_x;
    logic [CNT_W-1:0]               pixel_y;
    logic [NUM_SPRITES-1:0]         spr_start;
    logic                           frame_start;
    logic                           hsync;
    logic                           vsync;
    logic                           video_on;
    logic [COLOR_W-1:0]             rgb;

    modport master (
        input  spr_en, spr_y, spr_color, bg_color, spr_draw,
        output pixel_x, pixel_y, spr_start, frame_start, hsync, vsync, video_on, rgb
    );

    modport slave (
        output spr_en, spr_y, spr_color, bg_color, spr_draw,
        input  pixel_x, pixel_y, spr_start, frame_start, hsync, vsync, video_on, rgb
    );
endinterface

// File: rtl/sprite_scan_ctrl.sv
// Raster scan generator, per-sprite start scheduler and priority compositor.
// Counter value t appears on rgb/hsync/vsync/video_on two clocks later.
module sprite_scan_ctrl #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned COLOR_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    sprite_scan_if.master bus
);
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_LO  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_HI  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_LO  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_HI  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRED = 2'd2
    } spr_state_t;

    logic [CNT_W-1:0]       r_x;
    logic [CNT_W-1:0]       r_y;
    logic [CNT_W-1:0]       w_x_nxt;
    logic [CNT_W-1:0]       w_y_nxt;
    logic                   r_frame_start;
    logic                   w_frame_start_nxt;

    logic [NUM_SPRITES-1:0] r_shadow_en;
    logic [CNT_W-1:0]       r_shadow_y  [NUM_SPRITES];
    logic [CNT_W-1:0]       w_fire_line [NUM_SPRITES];
    spr_state_t             r_state     [NUM_SPRITES];
    spr_state_t             w_state_nxt [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_spr_start;
    logic [NUM_SPRITES-1:0] w_start_nxt;

    logic                   w_hsync_raw;
    logic                   w_vsync_raw;
    logic                   w_vis_raw;
    logic                   r_hs_d1, r_vs_d1, r_vis_d1;
    logic                   r_hs_d2, r_vs_d2, r_vis_d2;
    logic [COLOR_W-1:0]     w_pix_nxt;
    logic [COLOR_W-1:0]     r_rgb;

    // Next raster position: x wraps each line, y advances on the x wrap.
    always_comb begin
        w_x_nxt = r_x + CNT_W'(1);
        w_y_nxt = r_y;
        if (r_x == H_LAST) begin
            w_x_nxt = '0;
            w_y_nxt = (r_y == V_LAST) ? '0 : r_y + CNT_W'(1);
        end
        w_frame_start_nxt = (w_x_nxt == '0) && (w_y_nxt == V_VIS_C);
    end

    // Raster counters and the vertical-blank entry pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    // Latch sprite placement once per frame so mid-frame edits wait for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_en <= '0;
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                r_shadow_y[i] <= '0;
            end
        end else if (r_frame_start) begin
            r_shadow_en <= bus.spr_en;
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                r_shadow_y[i] <= bus.spr_y[CNT_W*i +: CNT_W];
            end
        end
    end

    // Per-sprite scheduler: arm at frame start, pulse once on the line above the sprite.
    always_comb begin
        for (int i = 0; i < int'(NUM_SPRITES); i++) begin
            w_state_nxt[i] = r_state[i];
            w_start_nxt[i] = 1'b0;
            // Line 0 sprites are armed from the last blank line, after the frame latch.
            w_fire_line[i] = (r_shadow_y[i] == '0) ? V_LAST : r_shadow_y[i] - CNT_W'(1);
            if (r_frame_start) begin
                if (bus.spr_en[i] && (bus.spr_y[CNT_W*i +: CNT_W] < V_VIS_C)) begin
                    w_state_nxt[i] = S_ARMED;
                end else begin
                    w_state_nxt[i] = S_IDLE;
                end
            end else begin
                case (r_state[i])
                    S_ARMED: begin
                        if (r_shadow_en[i] && (r_shadow_y[i] < V_VIS_C) &&
                            (w_x_nxt == H_VIS_C) && (w_y_nxt == w_fire_line[i])) begin
                            w_start_nxt[i] = 1'b1;
                            w_state_nxt[i] = S_FIRED;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = r_state[i];
                    end
                endcase
            end
        end
    end

    // Scheduler state and registered start pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spr_start <= '0;
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                r_state[i] <= S_IDLE;
            end
        end else begin
            r_spr_start <= w_start_nxt;
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // Raw sync and visibility decoded from the current counter value.
    always_comb begin
        w_hsync_raw = !((r_x >= H_SYNC_LO) && (r_x < H_SYNC_HI));
        w_vsync_raw = !((r_y >= V_SYNC_LO) && (r_y < V_SYNC_HI));
        w_vis_raw   = (r_x < H_VIS_C) && (r_y < V_VIS_C);
    end

    // Two-stage delay so sync and visibility line up with the composited pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_d1  <= 1'b1;
            r_vs_d1  <= 1'b1;
            r_vis_d1 <= 1'b0;
            r_hs_d2  <= 1'b1;
            r_vs_d2  <= 1'b1;
            r_vis_d2 <= 1'b0;
        end else begin
            r_hs_d1  <= w_hsync_raw;
            r_vs_d1  <= w_vsync_raw;
            r_vis_d1 <= w_vis_raw;
            r_hs_d2  <= r_hs_d1;
            r_vs_d2  <= r_vs_d1;
            r_vis_d2 <= r_vis_d1;
        end
    end

    // Lowest-index active drawer wins; background otherwise; black outside the visible area.
    always_comb begin
        w_pix_nxt = bus.bg_color;
        for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
            if (bus.spr_draw[i]) begin
                w_pix_nxt = bus.spr_color[COLOR_W*i +: COLOR_W];
            end
        end
        if (!r_vis_d1) begin
            w_pix_nxt = '0;
        end
    end

    // Registered pixel output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_pix_nxt;
        end
    end

    assign bus.pixel_x     = r_x;
    assign bus.pixel_y     = r_y;
    assign bus.frame_start = r_frame_start;
    assign bus.spr_start   = r_spr_start;
    assign bus.hsync       = r_hs_d2;
    assign bus.vsync       = r_vs_d2;
    assign bus.video_on    = r_vis_d2;
    assign bus.rgb         = r_rgb;

endmodule

// File: tb/tb_sprite_scan_ctrl.sv
// Directed bench: a full-size 640x480 instance for line timing and compositing,
// and a reduced-geometry instance (24x17 total) for whole-frame start scheduling.
module tb_sprite_scan_ctrl;
    localparam int unsigned NS = 4;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_scan_if #(.NUM_SPRITES(NS), .COLOR_W(CW)) bus_a ();
    sprite_scan_if #(.NUM_SPRITES(NS), .COLOR_W(CW)) bus_b ();

    sprite_scan_ctrl u_full (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    // Small raster: H 16/2/4/2 (total 24), V 12/1/2/2 (total 17), 408 cycles per frame.
    sprite_scan_ctrl #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Monitor state for the small instance.
    int       fs_cnt  = 0;
    int       fs_x[$];
    int       fs_y[$];
    int       lg_f[$];
    int       lg_x[$];
    int       lg_y[$];
    logic [3:0] lg_b[$];
    int       hs_low  = 0;
    int       vs_low  = 0;
    int       hs_snap = -1;
    int       vs_snap = -1;
    int       max_x   = 0;
    int       max_y   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Log start pulses, frame starts and sync activity of the small instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_b.frame_start) begin
                fs_cnt++;
                fs_x.push_back(int'(bus_b.pixel_x));
                fs_y.push_back(int'(bus_b.pixel_y));
                if (fs_cnt == 2) begin
                    hs_snap = hs_low;
                    vs_snap = vs_low;
                end
                hs_low = 0;
                vs_low = 0;
            end
            if (!bus_b.hsync) hs_low++;
            if (!bus_b.vsync) vs_low++;
            if (bus_b.spr_start != '0) begin
                lg_f.push_back(fs_cnt);
                lg_x.push_back(int'(bus_b.pixel_x));
                lg_y.push_back(int'(bus_b.pixel_y));
                lg_b.push_back(bus_b.spr_start);
            end
            if (int'(bus_b.pixel_x) > max_x) max_x = int'(bus_b.pixel_x);
            if (int'(bus_b.pixel_y) > max_y) max_y = int'(bus_b.pixel_y);
        end
    end

    task automatic wait_xy_a(input int x, input int y, input int limit);
        bit found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            step();
            if (int'(bus_a.pixel_x) == x && int'(bus_a.pixel_y) == y) found = 1'b1;
        end
        chk($sformatf("reach_a_%0d_%0d", x, y), 32'(found), 32'd1);
    endtask

    task automatic wait_xy_b(input int x, input int y, input int limit);
        bit found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            step();
            if (int'(bus_b.pixel_x) == x && int'(bus_b.pixel_y) == y) found = 1'b1;
        end
        chk($sformatf("reach_b_%0d_%0d", x, y), 32'(found), 32'd1);
    endtask

    task automatic wait_fs(input int n, output int k);
        k = 0;
        while (fs_cnt < n && k < 2000) begin
            step();
            k++;
        end
        chk($sformatf("frame_start_%0d_seen", n), 32'(fs_cnt >= n), 32'd1);
    endtask

    task automatic chk_rst_b(input string p);
        chk({p, "_x"},   32'(bus_b.pixel_x),     32'd0);
        chk({p, "_y"},   32'(bus_b.pixel_y),     32'd0);
        chk({p, "_st"},  32'(bus_b.spr_start),   32'd0);
        chk({p, "_fs"},  32'(bus_b.frame_start), 32'd0);
        chk({p, "_hs"},  32'(bus_b.hsync),       32'd1);
        chk({p, "_vs"},  32'(bus_b.vsync),       32'd1);
        chk({p, "_von"}, 32'(bus_b.video_on),    32'd0);
        chk({p, "_rgb"}, 32'(bus_b.rgb),         32'd0);
    endtask

    task automatic chk_log(input int idx, input int f, input int x, input int y, input logic [3:0] b);
        chk($sformatf("start%0d_frame", idx), 32'(lg_f[idx]), 32'(f));
        chk($sformatf("start%0d_x", idx),     32'(lg_x[idx]), 32'(x));
        chk($sformatf("start%0d_y", idx),     32'(lg_y[idx]), 32'(y));
        chk($sformatf("start%0d_bits", idx),  32'(lg_b[idx]), 32'(b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        int lo_cnt;
        int lo_first;
        int lo_last;

        bus_a.spr_en    = 4'b0000;
        bus_a.spr_y     = '0;
        bus_a.spr_color = 32'h44332211;
        bus_a.bg_color  = 8'h55;
        bus_a.spr_draw  = 4'b0000;

        // s0 y=5, s1 y=0, s2 y=12 (never), s3 y=5 but disabled.
        bus_b.spr_en    = 4'b0111;
        bus_b.spr_y     = {10'd5, 10'd12, 10'd0, 10'd5};
        bus_b.spr_color = 32'h44332211;
        bus_b.bg_color  = 8'h5A;
        bus_b.spr_draw  = 4'b0000;

        rst = 1'b1;
        repeat (3) step();
        chk_rst_b("rst0");
        chk("rst0_a_x",   32'(bus_a.pixel_x), 32'd0);
        chk("rst0_a_rgb", 32'(bus_a.rgb),     32'd0);

        rst = 1'b0;
        step();
        chk("run_b_x", 32'(bus_b.pixel_x), 32'd1);
        chk("run_b_y", 32'(bus_b.pixel_y), 32'd0);

        // First frame start at linear index 12*24 = 288, one step already taken.
        wait_fs(1, k);
        chk("fs1_latency", 32'(k), 32'd287);
        chk("no_start_before_fs", 32'(lg_b.size()), 32'd0);
        chk("fs1_x", 32'(fs_x[0]), 32'd0);
        chk("fs1_y", 32'(fs_y[0]), 32'd12);

        // Mid-frame edit after sprite 0 has fired.
        wait_xy_b(0, 8, 1000);
        chk("frame1_starts_by_line8", 32'(lg_b.size()), 32'd2);
        bus_b.spr_y  = {10'd7, 10'd12, 10'd0, 10'd7};
        bus_b.spr_en = 4'b1111;

        wait_fs(2, k);
        chk("frame1_start_count", 32'(lg_b.size()), 32'd2);
        chk("frame1_hsync_low", 32'(hs_snap), 32'd68);
        chk("frame1_vsync_low", 32'(vs_snap), 32'd48);

        // Edit during frame 2 before sprite 0 fires; shadow must hold y=7.
        wait_xy_b(0, 2, 1000);
        bus_b.spr_y = {10'd7, 10'd12, 10'd0, 10'd9};

        wait_fs(3, k);
        chk("frame2_start_count", 32'(lg_b.size()), 32'd4);
        if (lg_b.size() >= 4) begin
            chk_log(0, 1, 16, 16, 4'b0010);
            chk_log(1, 1, 16,  4, 4'b0001);
            chk_log(2, 2, 16, 16, 4'b0010);
            chk_log(3, 2, 16,  6, 4'b1001);
        end
        chk("fs3_y",  32'(fs_y[2]), 32'd12);
        chk("fs2_x",  32'(fs_x[1]), 32'd0);
        chk("max_x",  32'(max_x),   32'd23);
        chk("max_y",  32'(max_y),   32'd16);

        // Full-size instance: line wrap and hsync window.
        wait_xy_a(799, 1, 3000);
        step();
        chk("a_wrap_x", 32'(bus_a.pixel_x), 32'd0);
        chk("a_wrap_y", 32'(bus_a.pixel_y), 32'd2);
        lo_cnt   = 0;
        lo_first = -1;
        lo_last  = -1;
        for (int i = 0; i < 800; i++) begin
            step();
            if (!bus_a.hsync) begin
                lo_cnt++;
                if (lo_first < 0) lo_first = int'(bus_a.pixel_x);
                lo_last = int'(bus_a.pixel_x);
            end
        end
        chk("a_hsync_low_cycles", 32'(lo_cnt),   32'd96);
        chk("a_hsync_first_low",  32'(lo_first), 32'd658);
        chk("a_hsync_last_low",   32'(lo_last),  32'd753);
        chk("a_vsync_line2",      32'(bus_a.vsync), 32'd1);

        // Compositor: draw bits presented while the counter shows t+1.
        wait_xy_a(11, 10, 10000);
        bus_a.spr_draw = 4'b0110;
        step();
        chk("rgb_prio_0110", 32'(bus_a.rgb),      32'h22);
        chk("von_visible",   32'(bus_a.video_on), 32'd1);
        bus_a.spr_draw = 4'b0000;
        step();
        chk("rgb_bg",        32'(bus_a.rgb),      32'h55);
        bus_a.spr_draw = 4'b1111;
        step();
        chk("rgb_prio_1111", 32'(bus_a.rgb),      32'h11);
        bus_a.spr_draw = 4'b1000;
        step();
        chk("rgb_spr3",      32'(bus_a.rgb),      32'h44);
        bus_a.spr_draw = 4'b0000;
        wait_xy_a(641, 10, 1000);
        bus_a.spr_draw = 4'b1111;
        step();
        chk("rgb_hblank",    32'(bus_a.rgb),      32'h00);
        chk("von_hblank",    32'(bus_a.video_on), 32'd0);
        bus_a.spr_draw = 4'b0000;

        // Mid-frame reset on the small instance while s0/s3 are still armed.
        wait_xy_b(10, 5, 1000);
        rst = 1'b1;
        #1;
        chk_rst_b("rst1");
        step();
        step();
        lg_f.delete();
        lg_x.delete();
        lg_y.delete();
        lg_b.delete();
        fs_cnt = 0;
        rst = 1'b0;
        step();
        chk("restart_b_x", 32'(bus_b.pixel_x), 32'd1);
        chk("restart_b_y", 32'(bus_b.pixel_y), 32'd0);
        wait_fs(1, k);
        chk("restart_fs_latency", 32'(k), 32'd287);
        chk("restart_no_start",   32'(lg_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
